// File: rtl/uart_tx_frame_sequencer.sv
// uart_tx_frame_sequencer
// Transmit-side UART frame controller. Accepts one word per valid/ready
// handshake, latches the frame configuration with it, and serialises
// start, data (LSB first), optional parity and one or two stop bits on tx.
//
// Optional feature macro: UART_TX_BREAK_EN adds the sendBreak input and a
// BREAK state that holds tx low for (frame length + 1) bit periods.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   cfgDataBits          data bits 5..8 (other values mean 8)
//   cfgParityEnable      insert parity bit
//   cfgParityOdd         0 even, 1 odd parity
//   cfgTwoStop           0 one stop bit, 1 two stop bits
//   cfgOverSample13      0 16 ticks per bit, 1 13 ticks per bit
//   cfgBaudDivisor       clocks per oversample tick (0 means 1)
//   txData/txValid/txReady  word input handshake
//   tx                   registered serial line, idle high
//   busy                 frame (or break) in progress
//   frameDone            one-cycle pulse after the last bit completes
//   sendBreak            break request (UART_TX_BREAK_EN only)
//   dbgState             current FSM state for observation
//
// Handshake: a word (or break) is taken on a rising edge where txValid (or
// sendBreak) and txReady are both high; txReady is high only in IDLE and
// does not depend on txValid.
module uart_tx_frame_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            cfgDataBits,
   input  logic                  cfgParityEnable,
   input  logic                  cfgParityOdd,
   input  logic                  cfgTwoStop,
   input  logic                  cfgOverSample13,
   input  logic [DIV_WIDTH-1:0]  cfgBaudDivisor,
   input  logic [DATA_WIDTH-1:0] txData,
   input  logic                  txValid,
   output logic                  txReady,
   output logic                  tx,
   output logic                  busy,
   output logic                  frameDone,
`ifdef UART_TX_BREAK_EN
   input  logic                  sendBreak,
`endif
   output logic [2:0]            dbgState
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2
`ifdef UART_TX_BREAK_EN
      , S_BREAK
`endif
   } state_t;

   state_t               state_q, state_d;
   logic [7:0]           data_q, data_d;
   logic [3:0]           bits_q, bits_d;
   logic                 par_en_q, par_en_d;
   logic                 par_q, par_d;
   logic                 two_q, two_d;
   logic                 os13_q, os13_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
   logic [3:0]           os_cnt_q, os_cnt_d;
   logic [3:0]           bit_idx_q, bit_idx_d;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;
`ifdef UART_TX_BREAK_EN
   logic [3:0]           brk_last_q, brk_last_d;
`endif

   logic                 tick, bit_end;
   logic [3:0]           bits_in;
   logic [7:0]           mask_in;

   // Decode the requested width; anything outside 5..8 is a full byte.
   always_comb begin
      bits_in = 4'd8;
      mask_in = 8'hFF;
      case (cfgDataBits)
         4'd5: begin bits_in = 4'd5; mask_in = 8'h1F; end
         4'd6: begin bits_in = 4'd6; mask_in = 8'h3F; end
         4'd7: begin bits_in = 4'd7; mask_in = 8'h7F; end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      bits_d    = bits_q;
      par_en_d  = par_en_q;
      par_d     = par_q;
      two_d     = two_q;
      os13_d    = os13_q;
      div_d     = div_q;
      div_cnt_d = div_cnt_q;
      os_cnt_d  = os_cnt_q;
      bit_idx_d = bit_idx_q;
      done_d    = 1'b0;
      tx_d      = 1'b1;
`ifdef UART_TX_BREAK_EN
      brk_last_d = brk_last_q;
`endif

      tick    = (div_cnt_q == (div_q - DIV_WIDTH'(1)));
      bit_end = tick && (os_cnt_q == (os13_q ? 4'd12 : 4'd15));

      // Tick generator runs only while a frame is active; it wraps to zero
      // on the last bitEnd, so it is already clear when IDLE is reached.
      if (state_q != S_IDLE) begin
         div_cnt_d = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
         if (tick) os_cnt_d = bit_end ? 4'd0 : os_cnt_q + 4'd1;
      end

      case (state_q)
         S_IDLE: begin
`ifdef UART_TX_BREAK_EN
            if (sendBreak || txValid) begin
`else
            if (txValid) begin
`endif
               data_d    = txData[7:0];
               bits_d    = bits_in;
               par_en_d  = cfgParityEnable;
               par_d     = (^(txData[7:0] & mask_in)) ^ cfgParityOdd;
               two_d     = cfgTwoStop;
               os13_d    = cfgOverSample13;
               div_d     = (cfgBaudDivisor == '0) ? DIV_WIDTH'(1) : cfgBaudDivisor;
               div_cnt_d = '0;
               os_cnt_d  = 4'd0;
               bit_idx_d = 4'd0;
               state_d   = S_START;
`ifdef UART_TX_BREAK_EN
               // Break length in bits is frame length + 1; store the last index.
               brk_last_d = bits_in + {3'd0, cfgParityEnable} + (cfgTwoStop ? 4'd2 : 4'd1) + 4'd1;
               if (sendBreak) state_d = S_BREAK;
`endif
            end
         end
         S_START: if (bit_end) state_d = S_DATA;
         S_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == bits_q - 4'd1) state_d = par_en_q ? S_PARITY : S_STOP1;
               else                            bit_idx_d = bit_idx_q + 4'd1;
            end
         end
         S_PARITY: if (bit_end) state_d = S_STOP1;
         S_STOP1: begin
            if (bit_end) begin
               state_d = two_q ? S_STOP2 : S_IDLE;
               done_d  = ~two_q;
            end
         end
         S_STOP2: begin
            if (bit_end) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
`ifdef UART_TX_BREAK_EN
         S_BREAK: begin
            // bit_idx counts elapsed break bit periods.
            if (bit_end) begin
               if (bit_idx_q == brk_last_q) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // tx is registered from the next state so it changes on the same edge.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = data_d[bit_idx_d[2:0]];
         S_PARITY: tx_d = par_d;
`ifdef UART_TX_BREAK_EN
         S_BREAK:  tx_d = 1'b0;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         data_q    <= '0;
         bits_q    <= 4'd8;
         par_en_q  <= 1'b0;
         par_q     <= 1'b0;
         two_q     <= 1'b0;
         os13_q    <= 1'b0;
         div_q     <= DIV_WIDTH'(1);
         div_cnt_q <= '0;
         os_cnt_q  <= 4'd0;
         bit_idx_q <= 4'd0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
`ifdef UART_TX_BREAK_EN
         brk_last_q <= 4'd0;
`endif
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         bits_q    <= bits_d;
         par_en_q  <= par_en_d;
         par_q     <= par_d;
         two_q     <= two_d;
         os13_q    <= os13_d;
         div_q     <= div_d;
         div_cnt_q <= div_cnt_d;
         os_cnt_q  <= os_cnt_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
`ifdef UART_TX_BREAK_EN
         brk_last_q <= brk_last_d;
`endif
      end
   end

   assign txReady   = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign tx        = tx_q;
   assign frameDone = done_q;
   assign dbgState  = state_q;

endmodule

// File: tb/tb_uart_tx_frame_sequencer.sv
// Bench for uart_tx_frame_sequencer: per-cycle comparison of tx, txReady,
// busy and frameDone against a queue of expected line levels built from
// the frame rules, plus literal checks from the worked examples.
module tb_uart_tx_frame_sequencer;

`ifdef UART_TX_BREAK_EN
   localparam bit BRK_EN = 1'b1;
`else
   localparam bit BRK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  cfgDataBits = 4'd8;
   logic        cfgParityEnable = 1'b0;
   logic        cfgParityOdd = 1'b0;
   logic        cfgTwoStop = 1'b0;
   logic        cfgOverSample13 = 1'b0;
   logic [15:0] cfgBaudDivisor = 16'd1;
   logic [7:0]  txData = 8'h00;
   logic        txValid = 1'b0;
   logic        sendBreak = 1'b0;
   logic        txReady, tx, busy, frameDone;
   logic [2:0]  dbgState;

   uart_tx_frame_sequencer #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
      .clk(clk), .reset(reset),
      .cfgDataBits(cfgDataBits), .cfgParityEnable(cfgParityEnable),
      .cfgParityOdd(cfgParityOdd), .cfgTwoStop(cfgTwoStop),
      .cfgOverSample13(cfgOverSample13), .cfgBaudDivisor(cfgBaudDivisor),
      .txData(txData), .txValid(txValid), .txReady(txReady),
      .tx(tx), .busy(busy), .frameDone(frameDone),
`ifdef UART_TX_BREAK_EN
      .sendBreak(sendBreak),
`endif
      .dbgState(dbgState)
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   int done_cnt = 0;

   logic [0:0] exp_q[$];
   logic       exp_done = 1'b0;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   // Bit sequence of one frame (or break), index 0 sent first, and the
   // number of clocks each bit lasts.
   task automatic build_frame(input logic [3:0] db, input logic pe, input logic po,
                              input logic ts, input logic o13, input logic [15:0] dv,
                              input logic [7:0] d, input logic brk,
                              output logic [15:0] seq, output int nbits, output int per);
      int nb;
      logic ones;
      nb  = (db >= 5 && db <= 8) ? int'(db) : 8;
      per = ((dv == 0) ? 1 : int'(dv)) * (o13 ? 13 : 16);
      seq = '0;
      if (brk) begin
         nbits = 1 + nb + (pe ? 1 : 0) + (ts ? 2 : 1) + 1;
      end else begin
         ones = 1'b0;
         for (int i = 0; i < nb; i++) begin
            seq[1 + i] = d[i];
            ones ^= d[i];
         end
         nbits = 1 + nb;
         if (pe) begin seq[nbits] = ones ^ po; nbits++; end
         seq[nbits] = 1'b1; nbits++;
         if (ts) begin seq[nbits] = 1'b1; nbits++; end
      end
   endtask

   // Reference model: exp_q holds the tx level of every remaining frame cycle.
   initial begin
      logic [15:0] seq;
      int nbits, per;
      logic brk_req;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            exp_q.delete();
            exp_done = 1'b0;
         end else begin
            exp_done = 1'b0;
            brk_req = BRK_EN && sendBreak;
            if (exp_q.size() != 0) begin
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) exp_done = 1'b1;
            end else if (brk_req || txValid) begin
               build_frame(cfgDataBits, cfgParityEnable, cfgParityOdd, cfgTwoStop,
                           cfgOverSample13, cfgBaudDivisor, txData, brk_req, seq, nbits, per);
               for (int b = 0; b < nbits; b++)
                  for (int c = 0; c < per; c++) exp_q.push_back(seq[b]);
               acc_cnt++;
            end
         end
      end
   end

   // scoreboard compare, every cycle outside reset
   initial begin
      logic [3:0] e, a;
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            e = {(exp_q.size() != 0) ? exp_q[0][0] : 1'b1, exp_q.size() == 0,
                 exp_q.size() != 0, exp_done};
            a = {tx, txReady, busy, frameDone};
            check("cycle {tx,ready,busy,done}", int'(a), int'(e));
            if (frameDone === 1'b1) done_cnt++;
         end
      end
   end

   // watchdog
   initial begin
      #900000;
      check("watchdog", 0, 1);
      finish_run();
   end

   // driver tasks
   task automatic set_cfg(input logic [3:0] db, input logic pe, input logic po,
                          input logic ts, input logic o13, input logic [15:0] dv);
      cfgDataBits = db; cfgParityEnable = pe; cfgParityOdd = po;
      cfgTwoStop = ts; cfgOverSample13 = o13; cfgBaudDivisor = dv;
   endtask

   task automatic send(input logic [7:0] d, input logic brk, input logic keep);
      int start, g;
      start = acc_cnt;
      g = 0;
      txData = d;
      sendBreak = brk;
      txValid = !brk || keep;
      while (acc_cnt == start && g < 2000) begin
         @(posedge clk); #1;
         g++;
      end
      check("accepted", int'(acc_cnt != start), 1);
      sendBreak = 1'b0;
      if (!keep) txValid = 1'b0;
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 20000) begin
         @(posedge clk); #1;
         g++;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Clocks from the first tx=0 cycle to the frameDone cycle.
   task automatic measure(input string nm, input int exp_len);
      int cnt, g;
      g = 0;
      @(negedge clk);
      while (tx !== 1'b0 && g < 100) begin @(negedge clk); g++; end
      cnt = 1;
      g = 0;
      @(negedge clk);
      while (frameDone !== 1'b1 && g < 20000) begin
         cnt++;
         @(negedge clk);
         g++;
      end
      check(nm, cnt, exp_len);
   endtask

   initial begin
      logic [15:0] seq;
      int nbits, per, d0;

      // model pinned to the worked examples
      build_frame(4'd8, 0, 0, 0, 0, 16'd1, 8'hA5, 0, seq, nbits, per);
      check("model A5 8N1 bits", int'(seq), 842);
      check("model A5 8N1 length", nbits * per, 160);
      build_frame(4'd7, 1, 0, 1, 1, 16'd2, 8'h53, 0, seq, nbits, per);
      check("model 53 7E2 bits", int'(seq), 1702);
      check("model 53 7E2 length", nbits * per, 286);
      build_frame(4'd5, 1, 1, 0, 0, 16'd1, 8'hFF, 0, seq, nbits, per);
      check("model FF 5O1 bits", int'(seq), 190);
      build_frame(4'd5, 1, 0, 0, 0, 16'd1, 8'hFF, 0, seq, nbits, per);
      check("model FF 5E1 bits", int'(seq), 254);

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check("reset tx", int'(tx), 1);
      check("reset txReady", int'(txReady), 1);
      check("reset busy", int'(busy), 0);
      check("reset frameDone", int'(frameDone), 0);
      @(posedge clk); #2;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // directed frames from the worked examples
      set_cfg(4'd8, 0, 0, 0, 0, 16'd1);
      send(8'hA5, 0, 0);
      measure("A5 8N1 frame clocks", 160);
      wait_idle();

      set_cfg(4'd7, 1, 0, 1, 1, 16'd2);
      send(8'h53, 0, 0);
      measure("53 7E2 frame clocks", 286);
      wait_idle();

      set_cfg(4'd5, 1, 1, 0, 0, 16'd1);
      send(8'hFF, 0, 0);
      wait_idle();
      set_cfg(4'd5, 1, 0, 0, 0, 16'd1);
      send(8'hFF, 0, 0);
      wait_idle();

      // back-to-back with a width change mid-frame
      set_cfg(4'd8, 0, 0, 0, 0, 16'd1);
      d0 = done_cnt;
      send(8'h11, 0, 1);
      repeat (20) @(posedge clk);
      #1;
      cfgDataBits = 4'd5;
      send(8'h22, 0, 0);
      wait_idle();
      check("back-to-back frameDone count", done_cnt - d0, 2);

      // reset during data bit 3
      set_cfg(4'd8, 0, 0, 0, 0, 16'd1);
      send(8'h00, 0, 0);
      repeat (70) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("async reset tx", int'(tx), 1);
      check("async reset busy", int'(busy), 0);
      check("async reset txReady", int'(txReady), 1);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      @(posedge clk); #1;
      send(8'h3C, 0, 0);
      measure("frame after reset clocks", 160);
      wait_idle();

      if (BRK_EN) begin
         set_cfg(4'd8, 0, 0, 0, 0, 16'd1);
         send(8'h5A, 1, 1);
         measure("break clocks", 176);
         wait_idle();
         txValid = 1'b0;
         wait_idle();
      end

      // randomized frames, config scrambled mid-frame
      for (int f = 0; f < 40; f++) begin
         logic keep, brk;
         set_cfg(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 3)));
         brk  = BRK_EN && ($urandom_range(0, 7) == 0);
         keep = 1'($urandom_range(0, 1));
         send(8'($urandom), brk, keep);
         repeat ($urandom_range(1, 5)) @(posedge clk);
         #1;
         set_cfg(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 3)));
         txData = 8'($urandom);
         if (!keep) repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      txValid = 1'b0;
      wait_idle();

      finish_run();
   end

endmodule
